ipsxe_floating_point_result_checker: RTL
========================================

# ipsxe_floating_point_result_checker

Self-checking result comparator for the floating-point example design. It consumes DUT results through a valid/ready handshake and drives the read address of the golden-result ROM (one-cycle registered read). It compares each result against the golden word and reports per-vector mismatches, an error count, pass/fail and timeout to the example-design top.

## Interface
Parameters:
- EXP_WIDTH, 8, exponent width
- MAN_WIDTH, 23, mantissa width; W = 1+EXP_WIDTH+MAN_WIDTH
- NUM_VECTORS, 4, vectors per run (1..16)
- NAN_AWARE, 1, 1: any NaN matches any NaN; 0: bitwise compare (use 0 for integer-output ops)
- TIMEOUT_CYCLES, 1024, max cycles waiting for one DUT result

Ports (clk and rst: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse, begins a run
- dut_valid  in  1  DUT result valid
- dut_result  in  W  DUT result word
- dut_ready  out  1  checker accepts a result this cycle
- rom_rd_addr  out  4  golden ROM address, equals the current vector index
- rom_dout  in  W  golden ROM data, registered, one cycle after address
- busy  out  1  run in progress
- done  out  1  run finished, held until start or rst
- pass  out  1  valid while done; 1 if no mismatch and no timeout
- timeout  out  1  run aborted by timeout
- err_cnt  out  5  number of mismatching vectors
- mismatch_mask  out  NUM_VECTORS  bit k set if vector k mismatched

## Operation
- States: IDLE, WAIT, CMP, DONE.
- IDLE: start -> clear idx, err_cnt, mismatch_mask, timeout, and the timer; go to WAIT.
- WAIT: dut_ready=1. dut_valid & dut_ready -> latch dut_result, go to CMP. The timer counts cycles in WAIT. When the timer reaches TIMEOUT_CYCLES-1 without a transfer -> timeout=1, go to DONE.
- CMP: compare the latched result with rom_dout.
  - Mismatch -> set mismatch_mask[idx] and increment err_cnt.
  - idx==NUM_VECTORS-1 -> go to DONE. Otherwise increment idx, clear the timer, go to WAIT.
- DONE: done=1, pass=(err_cnt==0)&~timeout. start -> same action as from IDLE (restart). Stats persist until then.
- NaN rule (NAN_AWARE=1): a value is NaN if its exponent is all ones and its mantissa is nonzero. If both values are NaN, they match, ignoring sign and payload. Otherwise compare bitwise. ±inf and ±0 are compared bitwise (+0 ≠ -0).
- rom_rd_addr = idx, zero-extended to 4 bits. It is stable in WAIT and CMP.
- dut_valid outside WAIT is ignored and not buffered. The DUT must hold its result until the transfer.
- start while busy is ignored.

## Timing
- Reset values: dut_ready=0, rom_rd_addr=0, busy=0, done=0, pass=0, timeout=0, err_cnt=0, mismatch_mask=0; state=IDLE.
- rst during any state returns to IDLE on the next edge and discards partial stats.
- start at edge t -> WAIT (busy=1, dut_ready=1) in cycle t+1.
- Address is valid on the edge entering WAIT, so rom_dout is valid one cycle later. This is the earliest CMP cycle, so no extra fetch state is needed.
- Transfer in cycle c -> compare in c+1 -> WAIT again in c+2 with idx+1.
- Throughput: at most one vector per 2 cycles. A continuously-valid DUT is accepted every other cycle.
- The last CMP in cycle c gives done=1 and busy=0 from c+1. err_cnt and mismatch_mask are final in c+1.
- Timeout: the first WAIT cycle with no transfer is timer=0. If no transfer occurs by WAIT cycle TIMEOUT_CYCLES-1, DONE follows on the next edge.
- dut_valid asserted in the timeout cycle is not accepted.
- err_cnt never wraps, since NUM_VECTORS ≤ 16 < 32.

## Test plan
- All match (NUM_VECTORS=4, NAN_AWARE=1): golden is 0x40800000, 0x7FC00000, 0x7F800000, 0x00000000. Send the same values, dut_valid held high -> done 9 cycles after start, pass=1, err_cnt=0, mask=0000.
- NaN tolerance: vector 1 sent as 0xFFC00001 -> pass=1. Same stimulus with NAN_AWARE=0 -> err_cnt=1, mask=0010.
- Mismatch: vector 2 sent as 0xFF800000 (-inf) and vector 3 as 0x80000000 (-0) -> err_cnt=2, mask=1100, pass=0.
- Timeout (TIMEOUT_CYCLES=16): send vector 0, then hold dut_valid low -> done after 16 WAIT cycles, timeout=1, pass=0, rom_rd_addr=1.
- Handshake gaps: random dut_valid gaps of 0-5 cycles. Check rom_rd_addr steps 0,1,2,3 only after CMP, and dut_ready is never high in CMP.
- Restart/reset: start pulse while busy -> no effect. rst mid-run -> all outputs 0 next cycle. Then start in DONE -> stats cleared and a new run completes with pass=1.

Source files
------------

// File: rtl/ipsxe_floating_point_result_checker.sv
// Result checker for the floating-point example design.
// Accepts DUT results over a valid/ready handshake, addresses a golden ROM
// with a one-cycle registered read, and compares each result against the
// golden word. Optionally treats any two NaNs as equal.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - single-cycle pulse that begins a run
//   dut_valid/ready     - result handshake; dut_result is the result word
//   rom_rd_addr/dout    - golden ROM address (current vector) and data
//   busy, done, pass    - run status; pass is meaningful while done
//   timeout             - run aborted waiting for a DUT result
//   err_cnt             - number of mismatching vectors
//   mismatch_mask       - bit k set when vector k mismatched
module ipsxe_floating_point_result_checker #(
    parameter int unsigned EXP_WIDTH      = 8,
    parameter int unsigned MAN_WIDTH      = 23,
    parameter int unsigned NUM_VECTORS    = 4,
    parameter int unsigned NAN_AWARE      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 dut_valid,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]         dut_result,
    output logic                                 dut_ready,
    output logic [3:0]                           rom_rd_addr,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]         rom_dout,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic                                 timeout,
    output logic [4:0]                           err_cnt,
    output logic [NUM_VECTORS-1:0]               mismatch_mask
);

    localparam int unsigned W  = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned NV = NUM_VECTORS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    IDX_LAST   = 4'(NUM_VECTORS - 1);

    logic [1:0]    state, state_nx;
    logic [3:0]    idx, idx_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [4:0]    err_q, err_nx;
    logic [NV-1:0] mask_q, mask_nx;
    logic          to_q, to_nx;
    logic [W-1:0]  result_q, result_nx;
    logic          match_c;

    // NaN: exponent all ones with a nonzero mantissa.
    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[W-2 -: EXP_WIDTH]) && (|x[MAN_WIDTH-1:0]);
    endfunction

    // Bitwise equality, widened so that any NaN equals any NaN when enabled.
    always_comb begin
        match_c = (result_q == rom_dout);
        if (NAN_AWARE != 0 && is_nan(result_q) && is_nan(rom_dout)) begin
            match_c = 1'b1;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        timer_nx  = timer;
        err_nx    = err_q;
        mask_nx   = mask_q;
        to_nx     = to_q;
        result_nx = result_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_WAIT;
                    idx_nx   = 4'd0;
                    timer_nx = '0;
                    err_nx   = 5'd0;
                    mask_nx  = '0;
                    to_nx    = 1'b0;
                end
            end
            S_WAIT: begin
                // The timeout cycle wins over a late transfer; ready is low then.
                if (timer == TIMER_LAST) begin
                    to_nx    = 1'b1;
                    state_nx = S_DONE;
                end else if (dut_valid && dut_ready) begin
                    result_nx = dut_result;
                    state_nx  = S_CMP;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            S_CMP: begin
                if (!match_c) begin
                    mask_nx = mask_q | (NV'(1) << idx);
                    err_nx  = err_q + 5'd1;
                end
                if (idx == IDX_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    idx_nx   = idx + 4'd1;
                    timer_nx = '0;
                    state_nx = S_WAIT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 4'd0;
            timer     <= '0;
            err_q     <= 5'd0;
            mask_q    <= '0;
            to_q      <= 1'b0;
            result_q  <= '0;
            dut_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            timer     <= timer_nx;
            err_q     <= err_nx;
            mask_q    <= mask_nx;
            to_q      <= to_nx;
            result_q  <= result_nx;
            dut_ready <= (state_nx == S_WAIT) && (timer_nx != TIMER_LAST);
            busy      <= (state_nx == S_WAIT) || (state_nx == S_CMP);
            done      <= (state_nx == S_DONE);
            pass      <= (state_nx == S_DONE) && (err_nx == 5'd0) && !to_nx;
        end
    end

    assign rom_rd_addr   = idx;
    assign err_cnt       = err_q;
    assign mismatch_mask = mask_q;
    assign timeout       = to_q;

endmodule
